// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder: turns decoded field bundles into 32-bit words,
// tagging each emitted word with an auto-incrementing word address.
module riscv_instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              wrapped
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. The producer holds its payload stable while valid && !ready;
  // in_ready depends only on clear, out_valid and out_ready (no skid buffer).

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;
  localparam logic [2:0] FMT_JAL    = 3'd5;
  localparam logic [2:0] FMT_LUI    = 3'd6;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              err_q,       err_d;
  logic              wrapped_q,   wrapped_d;

  logic        accept;
  logic [31:0] enc_word;

  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_R:      enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
      FMT_I: begin
        // Shift-immediates carry shamt in imm[4:0] and srai's flag in bit 30.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc_word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else
          enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      FMT_LOAD:   enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      FMT_STORE:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      FMT_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      FMT_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      FMT_LUI:    enc_word = {imm[31:12], rd, 7'b0110111};
      default:    enc_word = 32'd0;
    endcase
  end

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    wrapped_d   = wrapped_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (fmt == 3'd7) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_instr_d = enc_word;
        out_addr_d  = addr_q;
        addr_d      = addr_q + ADDR_W'(1);
        if (addr_q == {ADDR_W{1'b1}}) wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= '0;
      addr_q      <= BASE;
      err_q       <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed self-checking bench for riscv_instr_encoder: a default-sized
// instance for encoding/handshake scenarios and an ADDR_W=2 one for wrapping.
module tb_riscv_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, w_in_valid, out_ready;
  logic [2:0]  fmt, funct3;
  logic        funct7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        in_ready, out_valid, err, wrapped;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;

  logic        w_in_ready, w_out_valid, w_err, w_wrapped;
  logic [31:0] w_out_instr;
  logic [1:0]  w_out_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .wrapped(wrapped)
  );

  riscv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr),
    .err(w_err), .wrapped(w_wrapped)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [2:0] f3, input logic f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    fmt = f; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b instr=%h addr=%0d, want 0/00000000/0",
               out_valid, out_instr, out_addr);
    end
    checks++;
    if (err !== 1'b0 || wrapped !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got err=%b wrapped=%b in_ready=%b, want 0/0/1",
               err, wrapped, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h003100B3 || out_addr !== 8'd0) begin
      errors++;
      $display("FAIL r_add: got valid=%b instr=%h addr=%0d, want 1/003100B3/0",
               out_valid, out_instr, out_addr);
    end
    drive(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h403100B3 || out_addr !== 8'd1) begin
      errors++;
      $display("FAIL r_sub: got valid=%b instr=%h addr=%0d, want 1/403100B3/1",
               out_valid, out_instr, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL r_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_formats();
    // addi, sw, lui, srai, beq, jal
    logic [2:0]  t_fmt [6] = '{3'd1, 3'd3, 3'd6, 3'd1, 3'd4, 3'd5};
    logic [2:0]  t_f3  [6] = '{3'b000, 3'b010, 3'b000, 3'b101, 3'b000, 3'b000};
    logic        t_f7  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]  t_rd  [6] = '{5'd5, 5'd0, 5'd5, 5'd1, 5'd0, 5'd1};
    logic [4:0]  t_rs1 [6] = '{5'd0, 5'd2, 5'd0, 5'd2, 5'd1, 5'd0};
    logic [4:0]  t_rs2 [6] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd2, 5'd0};
    logic [31:0] t_imm [6] = '{32'hFFFFFFFF, 32'd8, 32'h12345000, 32'd3, 32'hFFFFFFFC, 32'd8};
    logic [31:0] t_exp [6] = '{32'hFFF00293, 32'h00612423, 32'h123452B7,
                               32'h40315093, 32'hFE208EE3, 32'h008000EF};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(t_fmt[i], t_f3[i], t_f7[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== t_exp[i] || out_addr !== 8'(2 + i)) begin
        errors++;
        $display("FAIL format_%0d: got valid=%b instr=%h addr=%0d, want 1/%h/%0d",
                 i, out_valid, out_instr, out_addr, t_exp[i], 2 + i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    tick();
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00293 || out_addr !== 8'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got valid=%b instr=%h addr=%0d rdy=%b, want 1/FFF00293/8/0",
               out_valid, out_instr, out_addr, in_ready);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00293 || out_addr !== 8'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b instr=%h addr=%0d rdy=%b, want 1/FFF00293/8/0",
               out_valid, out_instr, out_addr, in_ready);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h003100B3 || out_addr !== 8'd9) begin
      errors++;
      $display("FAIL bp_second: got valid=%b instr=%h addr=%0d, want 1/003100B3/9",
               out_valid, out_instr, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_invalid_fmt();
    out_ready = 1'b1;
    drive(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    tick();
    drive(3'd7, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_consumed: got valid=%b err=%b, want 0/1", out_valid, err);
    end
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 8'd11 || out_instr !== 32'h003100B3 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_next_addr: got valid=%b addr=%0d instr=%h err=%b, want 1/11/003100B3/1",
               out_valid, out_addr, out_instr, err);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    drive(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    out_ready = 1'b1;
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_ready: got in_ready=%b, want 0", in_ready);
    end
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || wrapped !== 1'b0 || out_addr !== 8'd0 || out_instr !== 32'd0) begin
      errors++;
      $display("FAIL clear_state: got valid=%b err=%b wrapped=%b addr=%0d instr=%h, want 0/0/0/0/00000000",
               out_valid, err, wrapped, out_addr, out_instr);
    end
    drive(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_instr !== 32'h123452B7) begin
      errors++;
      $display("FAIL clear_restart: got valid=%b addr=%0d instr=%h, want 1/0/123452B7",
               out_valid, out_addr, out_instr);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    in_valid = 1'b0;
    w_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (w_out_valid !== 1'b1 || w_out_addr !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr_%0d: got valid=%b addr=%0d, want 1/%0d",
                 i, w_out_valid, w_out_addr, exp_addr[i]);
      end
      if (i == 2) begin
        checks++;
        if (w_wrapped !== 1'b0) begin
          errors++;
          $display("FAIL wrap_early: got wrapped=%b, want 0", w_wrapped);
        end
      end
    end
    w_in_valid = 1'b0;
    checks++;
    if (w_wrapped !== 1'b1 || w_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flag: got wrapped=%b err=%b, want 1/0", w_wrapped, w_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_invalid_fmt();
    test_clear();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
